// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring unsigned divide.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic             mop;
  logic [WIDTH-1:0] hi, lo, opb;

  logic             is_mul, is_div, iter, accept;
  logic [WIDTH-1:0] sres;
  logic [WIDTH:0]   msum, dt;
  logic [WIDTH-1:0] dsub;
  logic             dge;
  logic [WIDTH-1:0] hi_n, lo_n;

  assign is_mul = (op == 3'b100);
  assign is_div = (op == 3'b101);
  assign iter   = is_mul | (is_div & (|reg2));
  assign accept = start & (state != RUN);
  assign busy   = (state == RUN);

  always_comb begin
    sres = '0;
    unique case (op)
      3'b000: sres = reg1 & reg2;
      3'b001: sres = reg1 | reg2;
      3'b010: sres = reg1 + reg2;
      3'b011: sres = {reg2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      3'b100: sres = '0;
      3'b101: sres = '1;
      3'b110: sres = reg1 - reg2;
      3'b111: sres = {{(WIDTH-1){1'b0}},
                      ($signed(reg1) < $signed(reg2))};
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, FIN: state_n = (accept && iter) ? RUN : IDLE;
      RUN:       if (cnt == '0) state_n = FIN;
      default:   state_n = IDLE;
    endcase
  end

  // One iteration: mul adds then shifts right,
  // div shifts left then trial-subtracts.
  always_comb begin
    msum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    dt   = {hi, lo[WIDTH-1]};
    dge  = (dt >= {1'b0, opb});
    dsub = dt[WIDTH-1:0] - opb;
    if (mop) begin
      hi_n = msum[WIDTH:1];
      lo_n = {msum[0], lo[WIDTH-1:1]};
    end else begin
      hi_n = dge ? dsub : dt[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], dge};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      mop       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      opb       <= '0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      done      <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        cnt <= cnt - 1'b1;
        hi  <= hi_n;
        lo  <= lo_n;
        if (cnt == '0) begin
          result    <= lo_n;
          result_hi <= hi_n;
          zero      <= (lo_n == '0);
          dbz       <= 1'b0;
          done      <= 1'b1;
        end
      end else if (accept) begin
        if (iter) begin
          cnt <= CW'(WIDTH - 1);
          mop <= is_mul;
          hi  <= '0;
          lo  <= is_mul ? reg2 : reg1;
          opb <= is_mul ? reg1 : reg2;
        end else begin
          // divide by zero lands here as a one-cycle op
          result    <= sres;
          result_hi <= is_div ? reg1 : '0;
          zero      <= (sres == '0);
          dbz       <= is_div;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32).
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] reg1, reg2;
  logic [31:0] result, result_hi;
  logic        zero, busy, done, dbz;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] AND = 3'b000, OR = 3'b001, ADD = 3'b010, LUI = 3'b011;
  localparam logic [2:0] MUL = 3'b100, DIVU = 3'b101, SUB = 3'b110, SLT = 3'b111;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .reg1(reg1), .reg2(reg2), .result(result), .result_hi(result_hi),
    .zero(zero), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; reg1 = a; reg2 = b;
    @(negedge clk);
    start = 1'b0; op = 3'b111; reg1 = 32'hA5A5A5A5; reg2 = 32'h5A5A5A5A;
  endtask

  task automatic wait_done(input int lim, output int n, output int nb);
    n = 1; nb = 0;
    while (n <= lim && done !== 1'b1) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = ADD; reg1 = 32'd1; reg2 = 32'd1;
    repeat (2) @(negedge clk);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_result got=%h exp=0", result); end
    checks++; if (result_hi !== 32'h0) begin errors++; $display("FAIL rst_result_hi got=%h exp=0", result_hi); end
    checks++; if ({zero, busy, done, dbz} !== 4'b1000) begin errors++; $display("FAIL rst_flags zbdd got=%b exp=1000", {zero, busy, done, dbz}); end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, b, r;
    logic        z;
  } vec_t;

  task automatic test_single;
    vec_t v [11];
    v[0]  = '{SUB, 32'd5,          32'd5,          32'h0,          1'b1};
    v[1]  = '{AND, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   1'b0};
    v[2]  = '{OR,  32'h0F0F0000,   32'h000000F0,   32'h0F0F00F0,   1'b0};
    v[3]  = '{ADD, 32'hFFFFFFFF,   32'd1,          32'h0,          1'b1};
    v[4]  = '{ADD, 32'd7,          32'd8,          32'd15,         1'b0};
    v[5]  = '{SUB, 32'd0,          32'd1,          32'hFFFFFFFF,   1'b0};
    v[6]  = '{SLT, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0};
    v[7]  = '{SLT, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b1};
    v[8]  = '{SLT, 32'h80000000,   32'h7FFFFFFF,   32'd1,          1'b0};
    v[9]  = '{LUI, 32'hDEADBEEF,   32'h00001234,   32'h12340000,   1'b0};
    v[10] = '{LUI, 32'h0,          32'hFFFF0000,   32'h0,          1'b1};
    for (int i = 0; i < 11; i++) begin
      issue(v[i].o, v[i].a, v[i].b);
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single%0d_done_busy got=%b%b exp=10", i, done, busy); end
      checks++; if (result !== v[i].r) begin errors++; $display("FAIL single%0d_result got=%h exp=%h", i, result, v[i].r); end
      checks++; if ({result_hi, zero, dbz} !== {32'h0, v[i].z, 1'b0}) begin errors++; $display("FAIL single%0d_hi_z_dbz got=%h %b %b exp=0 %b 0", i, result_hi, zero, dbz, v[i].z); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || result !== v[i].r) begin errors++; $display("FAIL single%0d_hold done=%b result=%h exp=0 %h", i, done, result, v[i].r); end
    end
  endtask

  task automatic test_mul;
    int n, nb, bad;
    longint unsigned p;
    logic [31:0] held;
    held = result;
    issue(MUL, 32'hFFFFFFFF, 32'd2);
    n = 1; nb = 0; bad = 0;
    while (n <= 40 && done !== 1'b1) begin
      if (busy === 1'b1) nb++;
      if (result !== held || dbz !== 1'b0) bad++;
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", n); end
    checks++; if (nb !== 32) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=32", nb); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mul_intermediate_visible got=%0d exp=0", bad); end
    checks++; if ({result_hi, result} !== 64'h1_FFFFFFFE) begin errors++; $display("FAIL mul_ff_x2 got=%h_%h exp=00000001_fffffffe", result_hi, result); end
    checks++; if ({zero, dbz, busy} !== 3'b000) begin errors++; $display("FAIL mul_flags got=%b exp=000", {zero, dbz, busy}); end
    p = 64'h12345678 * 64'h9ABCDEF0;
    issue(MUL, 32'h12345678, 32'h9ABCDEF0);
    wait_done(40, n, nb);
    checks++; if ({result_hi, result} !== p) begin errors++; $display("FAIL mul_big got=%h_%h exp=%h n=%0d", result_hi, result, p, n); end
    issue(MUL, 32'd0, 32'd12345);
    wait_done(40, n, nb);
    checks++; if ({result_hi, result, zero} !== {64'h0, 1'b1}) begin errors++; $display("FAIL mul_zero got=%h_%h z=%b exp=0 z=1", result_hi, result, zero); end
  endtask

  task automatic test_div;
    int n, nb;
    issue(DIVU, 32'd100, 32'd7);
    wait_done(40, n, nb);
    checks++; if (n !== 33 || nb !== 32) begin errors++; $display("FAIL div_latency got=%0d/%0d exp=33/32", n, nb); end
    checks++; if ({result, result_hi, dbz} !== {32'd14, 32'd2, 1'b0}) begin errors++; $display("FAIL div_100_7 got=%0d r%0d dbz=%b exp=14 r2 dbz=0", result, result_hi, dbz); end
    issue(DIVU, 32'hDEADBEEF, 32'h1000);
    wait_done(40, n, nb);
    checks++; if ({result, result_hi} !== {32'h000DEADB, 32'h00000EEF}) begin errors++; $display("FAIL div_big got=%h r%h exp=000deadb r00000eef", result, result_hi); end
    issue(DIVU, 32'd5, 32'd9);
    wait_done(40, n, nb);
    checks++; if ({result, result_hi, zero} !== {32'd0, 32'd5, 1'b1}) begin errors++; $display("FAIL div_small got=%0d r%0d z=%b exp=0 r5 z=1", result, result_hi, zero); end
    issue(DIVU, 32'd9, 32'd0);
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL dbz_timing done,busy got=%b%b exp=10", done, busy); end
    checks++; if ({result, result_hi, dbz, zero} !== {32'hFFFFFFFF, 32'd9, 1'b1, 1'b0}) begin errors++; $display("FAIL dbz_values got=%h %h dbz=%b z=%b exp=ffffffff 9 1 0", result, result_hi, dbz, zero); end
    @(negedge clk);
    checks++; if (dbz !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL dbz_hold dbz=%b done=%b exp=1 0", dbz, done); end
    issue(ADD, 32'd1, 32'd1);
    checks++; if (dbz !== 1'b0 || result !== 32'd2) begin errors++; $display("FAIL dbz_clear dbz=%b result=%0d exp=0 2", dbz, result); end
  endtask

  task automatic test_back_to_back;
    int n, nb;
    issue(MUL, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    start = 1'b1; op = ADD; reg1 = 32'd100; reg2 = 32'd200;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ignore_busy busy=%b done=%b exp=1 0", busy, done); end
    wait_done(40, n, nb);
    checks++; if (n !== 29) begin errors++; $display("FAIL ignore_latency got=%0d exp=29", n); end
    checks++; if ({result_hi, result} !== 64'd15) begin errors++; $display("FAIL ignore_mul_result got=%h_%h exp=15", result_hi, result); end
    issue(ADD, 32'd10, 32'd20);
    checks++; if ({done, busy, result, result_hi} !== {2'b10, 32'd30, 32'd0}) begin errors++; $display("FAIL b2b_add done=%b busy=%b result=%0d hi=%0d exp=1 0 30 0", done, busy, result, result_hi); end
    issue(MUL, 32'd6, 32'd7);
    wait_done(40, n, nb);
    issue(DIVU, 32'd50, 32'd6);
    checks++; if (busy !== 1'b1 || result !== 32'd42) begin errors++; $display("FAIL b2b_iter busy=%b result=%0d exp=1 42", busy, result); end
    wait_done(40, n, nb);
    checks++; if ({n, result, result_hi} !== {32'd33, 32'd8, 32'd2}) begin errors++; $display("FAIL b2b_div n=%0d q=%0d r=%0d exp=33 8 2", n, result, result_hi); end
  endtask

  task automatic test_reset_abort;
    int seen;
    issue(DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({result, result_hi, zero, busy, done, dbz} !== {64'h0, 4'b1000}) begin errors++; $display("FAIL abort_reset got=%h %h zbdd=%b exp=0 0 1000", result, result_hi, {zero, busy, done, dbz}); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    issue(ADD, 32'd2, 32'd3);
    checks++; if (done !== 1'b1 || result !== 32'd5) begin errors++; $display("FAIL abort_then_add done=%b result=%0d exp=1 5", done, result); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'b000; reg1 = '0; reg2 = '0;
    @(negedge clk);
    test_reset;
    test_single;
    test_mul;
    test_div;
    test_back_to_back;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
